// File: rtl/param_chain_loader.sv
// Bit-serial master for the neuron parameter daisy chain.
// LOAD shifts host words into the chain MSB-first; READ recirculates the chain and captures it as words.
module param_chain_loader #(
  parameter int CHAIN_BITS = 22,
  parameter int WORD_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_load,
  input  logic                 start_read,
  input  logic [WORD_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 setup,
  output logic                 param_in,
  input  logic                 chain_out,
  output logic                 busy,
  output logic                 done
);

  localparam int NW = (CHAIN_BITS + WORD_BITS - 1) / WORD_BITS;
  localparam int R  = CHAIN_BITS - (NW - 1) * WORD_BITS;
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam int CW = $clog2(NW + 1);

  localparam logic [BW-1:0] FULL_BITS = BW'(WORD_BITS);
  localparam logic [BW-1:0] LAST_BITS = BW'(R);
  localparam logic [BW-1:0] ONE_BIT   = BW'(1);
  localparam logic [CW-1:0] NUM_WORDS = CW'(NW);
  localparam logic [CW-1:0] LAST_WORD = CW'(NW - 1);
  localparam logic [CW-1:0] ONE_WORD  = CW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t               state_q, state_d;
  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic [BW-1:0]        bits_q, bits_d;
  logic [CW-1:0]        words_q, words_d;
  logic [WORD_BITS-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 done_q, done_d;

  logic          setup_c;
  logic          in_ready_c;
  logic          param_in_c;
  logic          last_word;
  logic          hold_free;
  logic [BW-1:0] need;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bits_q      <= '0;
      words_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bits_q      <= bits_d;
      words_q     <= words_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bits_d      = bits_q;
    words_d     = words_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    setup_c     = 1'b0;
    in_ready_c  = 1'b0;
    param_in_c  = 1'b0;
    // words_q indexes the word being loaded or captured, so it also selects the short tail word
    last_word   = (words_q == LAST_WORD);
    need        = last_word ? LAST_BITS : FULL_BITS;
    hold_free   = !out_valid_q || out_ready;

    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LOAD;
          bits_d  = '0;
          words_d = '0;
        end else if (start_read) begin
          state_d = READ;
          sh_d    = '0;
          bits_d  = '0;
          words_d = '0;
        end
      end

      LOAD: begin
        setup_c    = (bits_q != '0);
        param_in_c = sh_q[WORD_BITS-1];
        // Accepting while the last bit shifts out keeps setup continuous across words
        in_ready_c = (bits_q <= ONE_BIT) && (words_q < NUM_WORDS);
        if (setup_c) begin
          sh_d   = sh_q << 1;
          bits_d = bits_q - ONE_BIT;
        end
        if (in_valid && in_ready_c) begin
          sh_d    = in_data;
          bits_d  = need;
          words_d = words_q + ONE_WORD;
        end
        if (setup_c && (bits_q == ONE_BIT) && (words_q == NUM_WORDS)) begin
          done_d = 1'b1;
        end
        if (done_q) begin
          state_d = IDLE;
        end
      end

      READ: begin
        param_in_c = chain_out;
        setup_c    = (words_q < NUM_WORDS) && (bits_q < need);
        if (setup_c) begin
          sh_d   = {sh_q[WORD_BITS-2:0], chain_out};
          bits_d = bits_q + ONE_BIT;
        end
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          if (words_q == NUM_WORDS) begin
            done_d = 1'b1;
          end
        end
        // A full capture waits here (setup low) until the holding register can take it
        if ((words_q < NUM_WORDS) && (bits_q == need) && hold_free) begin
          out_data_d  = last_word ? (sh_q << (WORD_BITS - R)) : sh_q;
          out_valid_d = 1'b1;
          bits_d      = '0;
          words_d     = words_q + ONE_WORD;
        end
        if (done_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign setup     = setup_c;
  assign in_ready  = in_ready_c;
  assign param_in  = param_in_c;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: doc/param_chain_loader.md
Name: param_chain_loader

Overview:
Serial master for the neuron parameter shift chain (setup / param_in / param_out daisy chain). It loads a stream of parameter words into the chain bit-serially and can read the chain back non-destructively by recirculating it. It sits between the host/config byte interface and the first neuron's param_in. The last neuron's param_out is returned on chain_out.

Parameters:
CHAIN_BITS, 22, total bits in the chain, i.e. the sum of INPUTS+BIAS_BITS over all chained neurons (default: 2 neurons of 8+3).
WORD_BITS, 8, width of the parallel word interface.

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start_load  input  1  single-cycle request to begin a LOAD; sampled in IDLE only.
start_read  input  1  single-cycle request to begin a READ; sampled in IDLE only.
in_data  input  WORD_BITS  parameter word, MSB transmitted first.
in_valid  input  1  in_data valid.
in_ready  output  1  loader accepts in_data this cycle.
out_data  output  WORD_BITS  read-back word, MSB = first bit read.
out_valid  output  1  out_data valid; holds until accepted.
out_ready  input  1  consumer accepts out_data.
setup  output  1  chain shift enable; the chain shifts one bit on each rising edge where setup=1.
param_in  output  1  serial bit into the chain.
chain_out  input  1  param_out of the last neuron.
busy  output  1  state is not IDLE.
done  output  1  one-cycle pulse when an operation completes.

Behaviour:
- States: IDLE, LOAD, READ. Reset forces IDLE asynchronously. All outputs are 0 during and after reset: setup, in_ready, out_valid, busy, done, param_in; out_data=0.
- Words: NW = ceil(CHAIN_BITS/WORD_BITS). The last word carries R = CHAIN_BITS-(NW-1)*WORD_BITS bits, taken from its MSBs.
- IDLE: setup=0. start_load moves to LOAD. start_read moves to READ. If both are asserted, start_load wins. Starts outside IDLE are ignored.
- LOAD:
  - A word is accepted on in_valid&in_ready into a shift register with a bit-count bl (WORD_BITS, or R for the final word).
  - in_ready=1 when bl==0, or when bl==1 and setup=1 (back-to-back with no bubble), and fewer than NW words have been accepted.
  - setup=1 exactly on cycles where bl>0. param_in = shift-register MSB. On each setup edge, bl decrements and the register shifts left.
  - With no word pending, setup=0 and the chain holds.
  - After exactly CHAIN_BITS setup edges: done=1 for the next cycle, then return to IDLE. The first bit sent ends at the far end of the chain.
- READ:
  - param_in = chain_out, combinational (recirculation). setup=1 whenever the capture register has room.
  - Each setup edge shifts chain_out into the capture register LSB and increments the captured-bit count.
  - When WORD_BITS bits are captured, or R bits for the final word (left-aligned, low bits zero), the word moves to the out_data holding register if it is empty or being accepted that cycle. Otherwise setup=0 (stall) until out_ready frees the holder.
  - out_valid/out_data stay stable until out_ready.
  - After CHAIN_BITS shifts, the chain contents are restored to their original positions. done pulses one cycle after the final word is accepted, then return to IDLE.
  - READ returns words identical to the last LOAD stream, with unused LSBs of the last word zeroed.
- busy=1 in LOAD and READ.
- Reset mid-operation: setup drops immediately and counters clear. Chain contents are then partially shifted and undefined; a full reload is required.
- There is no timeout. A stalled in_valid or out_ready holds the state indefinitely with setup=0.

Test Plan:
1. Reset mid-LOAD after 5 setup edges -> setup, busy, in_ready, out_valid go to 0 asynchronously. A fresh start_load then loads correctly.
2. start_load, then words 0xA5, 0x3C, 0xF0 with in_valid held high -> setup high for exactly 22 consecutive cycles. param_in sequence: 10100101 00111100 111100. done pulses once; busy falls.
3. Same LOAD with in_valid dropped for 3 cycles between words -> setup low during the gaps, total setup edges = 22, identical chain contents.
4. After test 2, start_read with out_ready=1 -> out_data 0xA5, 0x3C, 0xF0, then done. A second READ returns the same three words, confirming the chain is restored.
5. READ with out_ready=0 for 10 cycles after the first word -> setup stalls after 16 captured bits, out_data holds 0xA5, and no bits are lost on resume.
6. start_load and start_read asserted together in IDLE -> LOAD taken. start_read pulses during LOAD are ignored.
